// File: rtl/proc_pkg.sv
// Shared constants for the 16-bit processor front end: opcode encodings,
// default widths, opcode field position and the fetch state type.
package proc_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 5;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;

    localparam logic [2:0] OPC_MV  = 3'b000;
    localparam logic [2:0] OPC_MVI = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_SUB = 3'b011;

    typedef enum logic {
        EXPECT_INSTR = 1'b0,
        EXPECT_IMM   = 1'b1
    } fetch_state_e;

    function automatic logic [2:0] opcode_of(input logic [DATA_W_DEF-1:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Small prefetch FIFO: synchronous push/pop, flush, head word and fill count.
// Head reads as zero while empty so DIN never shows stale data.
module prefetch_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    always_ff @(posedge Clock) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

    // The parent's issue rule must keep these from ever firing.
    assert property (@(posedge Clock) disable iff (!Resetn)
        !(push && !pop && !flush && count == CW'(DEPTH)));
    assert property (@(posedge Clock) disable iff (!Resetn)
        !(pop && !flush && count == '0));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: walks the PC through a synchronous ROM, buffers
// returned words in a prefetch FIFO and tags mvi immediates at the head.
//
//   state        | meaning
//   EXPECT_INSTR | head word is an instruction (Run may assert)
//   EXPECT_IMM   | head word is the immediate following an mvi
module instr_fetch_unit
    import proc_pkg::*;
#(
    parameter int         DATA_W   = DATA_W_DEF,
    parameter int         ADDR_W   = ADDR_W_DEF,
    parameter int         PROG_LEN = 16,
    parameter int         DEPTH    = 4,
    parameter logic [2:0] OPC_MVI  = proc_pkg::OPC_MVI
) (
    input  logic              Clock,
    input  logic              Resetn,
    output logic [ADDR_W-1:0] RomAddr,
    output logic              RomRen,
    input  logic [DATA_W-1:0] RomQ,
    input  logic              Take,
    input  logic              Load,
    input  logic [ADDR_W-1:0] LoadAddr,
    output logic [DATA_W-1:0] DIN,
    output logic              DinValid,
    output logic              IsImm,
    output logic              Run,
    output logic              Underrun
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      state;
    fetch_state_e      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [CW-1:0]     count;
    logic [CW:0]       occupancy;
    logic              push;
    logic              pop;

    // Counting the in-flight read as occupied guarantees room for its return.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight);
    assign RomRen    = Resetn & ~Load & (occupancy < (CW+1)'(DEPTH));
    assign RomAddr   = pc;

    assign DinValid  = (count != '0);
    assign push      = inflight & ~Load;
    assign pop       = Take & DinValid & ~Load;
    assign IsImm     = (state == EXPECT_IMM);
    assign Run       = DinValid & ~IsImm;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pc       <= '0;
            inflight <= 1'b0;
        end else if (Load) begin
            pc       <= (int'(LoadAddr) >= PROG_LEN) ? '0 : LoadAddr;
            inflight <= 1'b0;
        end else if (RomRen) begin
            pc       <= (int'(pc) == PROG_LEN - 1) ? '0 : pc + ADDR_W'(1);
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Underrun <= 1'b0;
        end else if (Take && !DinValid && !Load) begin
            Underrun <= 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= EXPECT_INSTR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (Load) begin
            state_nxt = EXPECT_INSTR;
        end else if (pop) begin
            case (state)
                EXPECT_INSTR: if (opcode_of(DIN) == OPC_MVI) state_nxt = EXPECT_IMM;
                EXPECT_IMM:   state_nxt = EXPECT_INSTR;
                default:      state_nxt = EXPECT_INSTR;
            endcase
        end
    end

    prefetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .flush     (Load),
        .push      (push),
        .push_data (RomQ),
        .pop       (pop),
        .head      (DIN),
        .count     (count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random
// Take/Load traffic, compared every cycle against a queue-based fetch model.
module tb_instr_fetch_unit;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 5;
    localparam int PROG_LEN = 16;
    localparam int DEPTH    = 4;

    logic              Clock    = 1'b0;
    logic              Resetn   = 1'b0;
    logic [ADDR_W-1:0] RomAddr;
    logic              RomRen;
    logic [DATA_W-1:0] RomQ     = '0;
    logic              Take     = 1'b0;
    logic              Load     = 1'b0;
    logic [ADDR_W-1:0] LoadAddr = '0;
    logic [DATA_W-1:0] DIN;
    logic              DinValid;
    logic              IsImm;
    logic              Run;
    logic              Underrun;

    instr_fetch_unit #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .PROG_LEN (PROG_LEN),
        .DEPTH    (DEPTH),
        .OPC_MVI  (3'b001)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .RomAddr  (RomAddr),
        .RomRen   (RomRen),
        .RomQ     (RomQ),
        .Take     (Take),
        .Load     (Load),
        .LoadAddr (LoadAddr),
        .DIN      (DIN),
        .DinValid (DinValid),
        .IsImm    (IsImm),
        .Run      (Run),
        .Underrun (Underrun)
    );

    always #5 Clock = ~Clock;

    logic [DATA_W-1:0] rom [32];

    always @(posedge Clock) begin
        if (RomRen) RomQ <= rom[RomAddr];
    end

    // Reference model: words waiting for the processor, the address of the
    // read whose data arrives next cycle (-1 if none), PC and mode flags.
    logic [DATA_W-1:0] m_q [$];
    int                m_pend;
    int                m_pc;
    bit                m_imm;
    bit                m_under;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend  = -1;
        m_pc    = 0;
        m_imm   = 1'b0;
        m_under = 1'b0;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        Take   = 1'b0;
        Load   = 1'b0;
        @(posedge Clock);
        #1;
        check("reset_ren", RomRen, 0);
        check("reset_valid", DinValid, 0);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        model_reset();
    endtask

    task automatic cycle(input bit take, input bit load, input int laddr);
        bit                ren;
        bit                valid;
        logic [DATA_W-1:0] w;
        @(negedge Clock);
        Take     = take;
        Load     = load;
        LoadAddr = laddr[ADDR_W-1:0];
        #1;
        valid = (m_q.size() > 0);
        ren   = !load && ((m_q.size() + ((m_pend >= 0) ? 1 : 0)) < DEPTH);
        check("rom_ren",   RomRen,   ren);
        check("rom_addr",  RomAddr,  m_pc);
        check("din_valid", DinValid, valid);
        check("is_imm",    IsImm,    m_imm);
        check("run",       Run,      valid && !m_imm);
        check("underrun",  Underrun, m_under);
        if (valid) check("din", DIN, m_q[0]);
        @(posedge Clock);
        if (load) begin
            m_q.delete();
            m_pend = -1;
            m_pc   = (laddr >= PROG_LEN) ? 0 : laddr;
            m_imm  = 1'b0;
        end else begin
            if (take && !valid) m_under = 1'b1;
            if (take && valid) begin
                w = m_q.pop_front();
                if (m_imm)                 m_imm = 1'b0;
                else if (w[15:13] == 3'b001) m_imm = 1'b1;
            end
            if (m_pend >= 0) m_q.push_back(rom[m_pend]);
            if (ren) begin
                m_pend = m_pc;
                m_pc   = (m_pc + 1) % PROG_LEN;
            end else begin
                m_pend = -1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = DATA_W'($urandom);
        rom[0] = 16'h2000;
        rom[1] = 16'h0005;
        rom[2] = 16'h0400;
        rom[3] = 16'h4080;
        model_reset();

        // Idle after reset: first word after edge 2, then the FIFO fills.
        do_reset();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        #1;
        check("first_valid", DinValid, 1);
        check("first_din",   DIN,      16'h2000);
        check("first_run",   Run,      1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        #1;
        check("full_ren", RomRen, 0);

        // Take held: streams through the program and wraps past ROM[15].
        for (int i = 0; i < 24; i++) cycle(1, 0, 0);

        // Load while the head is an mvi immediate.
        cycle(0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        cycle(1, 0, 0);
        #1;
        check("imm_before_load", IsImm, 1);
        cycle(0, 1, 3);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        #1;
        check("imm_after_load", IsImm, 0);
        check("din_after_load", DIN,   16'h4080);

        // Take while empty right after reset.
        do_reset();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);
        #1;
        check("underrun_sticky", Underrun, 1);

        // Redirect with three buffered words and a read in flight.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);
        cycle(1, 1, 8);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        #1;
        check("redirect_valid", DinValid, 1);
        check("redirect_din",   DIN,      rom[8]);
        check("redirect_under", Underrun, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);

        // Asynchronous reset between edges.
        do_reset();
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        #3;
        Resetn = 1'b0;
        #1;
        check("async_valid", DinValid, 0);
        check("async_run",   Run,      0);
        check("async_imm",   IsImm,    0);
        check("async_under", Underrun, 0);
        check("async_ren",   RomRen,   0);
        model_reset();
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);

        // Random traffic, including out-of-range redirect targets.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 16) == 0, int'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
